// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit and anything that
// drives it (control unit, testbenches).
//   op_t      : operation selector carried on the op lines of muldiv_if
//   state_t   : control states of muldiv_unit
//   DIV0_QUOT : quotient reported for a zero divisor (all ones, sliced to
//               the instance width by the user)
// ---------------------------------------------------------------------------
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Wide enough for any sensible operand width; users slice [WIDTH-1:0].
   localparam int MAX_WIDTH = 64;
   localparam logic [MAX_WIDTH-1:0] DIV0_QUOT = '1;

   // Signed variants need magnitude extraction and a sign fix at the end.
   function automatic logic isSignedOp(input op_t op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   // Divide variants use the restoring path; the rest use shift-add.
   function automatic logic isDivOp(input op_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// ---------------------------------------------------------------------------
// muldiv_if
// Bundle between the execute-stage control unit (master) and muldiv_unit
// (slave).
//   start, op, a, b     : operation launch and its rs/rt operands
//   mthi, mtlo, wdata   : direct architectural writes of HI/LO
//   busy, done          : stall request and one-cycle result strobe
//   hi, lo              : architectural HI/LO contents
// ---------------------------------------------------------------------------
interface muldiv_if
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
);

   logic             start;
   op_t              op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             mthi;
   logic             mtlo;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   // The control unit drives requests and watches status/results.
   modport master (
      output start, op, a, b, mthi, mtlo, wdata,
      input  busy, done, hi, lo
   );

   // The multiply/divide unit consumes requests and publishes results.
   modport slave (
      input  start, op, a, b, mthi, mtlo, wdata,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/muldiv_abs.sv
// ---------------------------------------------------------------------------
// muldiv_abs
// Combinational magnitude and sign extractor, one instance per operand.
//   i_value  : raw operand
//   i_signed : treat i_value as two's complement
//   o_mag    : |i_value| as an unsigned number (most negative value maps to
//              itself, which is correct when read as unsigned)
//   o_neg    : operand was negative (always 0 for unsigned operations)
// ---------------------------------------------------------------------------
module muldiv_abs #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_value,
   input  logic             i_signed,
   output logic [WIDTH-1:0] o_mag,
   output logic             o_neg
);

   // Only signed operations look at the top bit; unsigned operands pass through.
   assign o_neg = i_signed & i_value[WIDTH-1];
   assign o_mag = o_neg ? (~i_value + 1'b1) : i_value;

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : muldiv_if slave port
//          start/op/a/b   launch an operation (accepted only in IDLE)
//          mthi/mtlo/wdata direct HI/LO writes (IDLE or DONE only)
//          busy           high while an operation is in flight
//          done           one-cycle pulse while HI/LO hold a new result
//          hi/lo          product halves, or remainder/quotient
// Operations run on magnitudes; the FIX state restores signs. HI/LO are
// updated on the edge entering DONE, WIDTH+2 edges after the accepting edge.
// ---------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic    clk,
   input  logic    rst,
   muldiv_if.slave bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   state_t             r_state;
   state_t             w_nextState;
   op_t                r_op;
   logic [WIDTH-1:0]   r_magA;
   logic [WIDTH-1:0]   r_magB;
   logic               r_negRes;
   logic               r_negA;
   logic               r_divZero;
   logic               r_primed;
   logic [CW-1:0]      r_count;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_signedOp;
   logic [WIDTH-1:0]   w_magA;
   logic [WIDTH-1:0]   w_magB;
   logic               w_negA;
   logic               w_negB;
   logic [WIDTH:0]     w_mulSum;
   logic [2*WIDTH-1:0] w_mulNext;
   logic [WIDTH:0]     w_divShift;
   logic [WIDTH:0]     w_divTrial;
   logic               w_qBit;
   logic [2*WIDTH-1:0] w_product;
   logic [WIDTH-1:0]   w_fixHi;
   logic [WIDTH-1:0]   w_fixLo;

   assign w_signedOp = isSignedOp(bus.op);

   muldiv_abs #(.WIDTH(WIDTH)) u_absA (
      .i_value  (bus.a),
      .i_signed (w_signedOp),
      .o_mag    (w_magA),
      .o_neg    (w_negA)
   );

   muldiv_abs #(.WIDTH(WIDTH)) u_absB (
      .i_value  (bus.b),
      .i_signed (w_signedOp),
      .o_mag    (w_magB),
      .o_neg    (w_negB)
   );

   // One shift-add multiply step: the multiplier sits in the low half of the
   // accumulator and is consumed LSB first while the partial product (with
   // its carry) shifts in from the top.
   assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_magA};
   assign w_mulNext = r_acc[0] ? {w_mulSum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

   // One restoring divide step. The partial remainder is WIDTH+1 bits only
   // while shifted and trial-subtracted; the stored remainder is always below
   // the divisor (or equal to the dividend prefix for a zero divisor), so
   // WIDTH bits hold it.
   assign w_divShift = {r_rem, r_quo[WIDTH-1]};
   assign w_divTrial = w_divShift - {1'b0, r_magB};
   assign w_qBit     = ~w_divTrial[WIDTH];

   // State register; reset drops any in-flight operation without a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. CALC spends its first cycle loading the iteration
   // registers from the captured magnitudes, then runs WIDTH steps.
   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_nextState = CALC;
            end
         end
         CALC: begin
            if (r_primed && (r_count == LAST_STEP)) begin
               w_nextState = FIX;
            end
         end
         FIX: begin
            w_nextState = DONE;
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Operand capture and the iterative datapath. Everything the operation
   // needs is copied on the accepting edge so the register file may move on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op      <= OP_MULT;
         r_magA    <= '0;
         r_magB    <= '0;
         r_negRes  <= 1'b0;
         r_negA    <= 1'b0;
         r_divZero <= 1'b0;
         r_primed  <= 1'b0;
         r_count   <= '0;
         r_acc     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_op      <= bus.op;
                  r_magA    <= w_magA;
                  r_magB    <= w_magB;
                  r_negRes  <= w_negA ^ w_negB;
                  r_negA    <= w_negA;
                  r_divZero <= (bus.b == '0);
                  r_primed  <= 1'b0;
                  r_count   <= '0;
               end
            end
            CALC: begin
               if (!r_primed) begin
                  r_primed <= 1'b1;
                  r_acc    <= {{WIDTH{1'b0}}, r_magB};
                  r_rem    <= '0;
                  r_quo    <= r_magA;
               end else begin
                  r_count <= r_count + 1'b1;
                  if (isDivOp(r_op)) begin
                     r_rem <= w_qBit ? w_divTrial[WIDTH-1:0] : w_divShift[WIDTH-1:0];
                     r_quo <= {r_quo[WIDTH-2:0], w_qBit};
                  end else begin
                     r_acc <= w_mulNext;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Sign correction applied while in FIX. The product is negated as a whole
   // 2*WIDTH value; the quotient follows sign(a)^sign(b) and the remainder
   // follows sign(a). A zero divisor forces the all-ones quotient, while the
   // remainder path already reproduces the original dividend.
   always_comb begin
      w_product = r_acc;
      w_fixHi   = '0;
      w_fixLo   = '0;
      if (isDivOp(r_op)) begin
         w_fixLo = r_negRes ? (~r_quo + 1'b1) : r_quo;
         w_fixHi = r_negA   ? (~r_rem + 1'b1) : r_rem;
         if (r_divZero) begin
            w_fixLo = DIV0_QUOT[WIDTH-1:0];
         end
      end else begin
         if (r_negRes) begin
            w_product = ~r_acc + 1'b1;
         end
         w_fixHi = w_product[2*WIDTH-1:WIDTH];
         w_fixLo = w_product[WIDTH-1:0];
      end
   end

   // Architectural HI/LO. Results land on the edge leaving FIX. MTHI/MTLO
   // only act in IDLE (and lose to an accepted start) or in DONE, where they
   // overwrite the freshly written result for that register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (r_state == FIX) begin
         r_hi <= w_fixHi;
         r_lo <= w_fixLo;
      end else if ((r_state == DONE) || ((r_state == IDLE) && !bus.start)) begin
         if (bus.mthi) begin
            r_hi <= bus.wdata;
         end
         if (bus.mtlo) begin
            r_lo <= bus.wdata;
         end
      end
   end

   assign bus.busy = (r_state == CALC) || (r_state == FIX);
   assign bus.done = (r_state == DONE);
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Directed bench for muldiv_unit. A cycle-level reference model keeps the
// architectural HI/LO contents and the in-flight countdown using plain
// arithmetic; a compare process checks busy/done/hi/lo against it on every
// falling edge, and directed literal checks pin the model's results.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int WIDTH   = 32;
   localparam int LATENCY = WIDTH + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   muldiv_if #(.WIDTH(WIDTH)) tbBus ();

   muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (tbBus)
   );

   always #5 clk = ~clk;

   int          numChecks = 0;
   int          numFails  = 0;
   bit          checkEn   = 1'b0;

   logic [31:0] mHi     = '0;
   logic [31:0] mLo     = '0;
   logic        mDone   = 1'b0;
   int          mRemain = 0;
   logic [63:0] mPend   = '0;

   // Architectural result of one operation, returned as {hi, lo}.
   function automatic logic [63:0] expectedResult(input op_t op, input logic [31:0] a,
                                                  input logic [31:0] b);
      longint          sa;
      longint          sb;
      longint unsigned ua;
      longint unsigned ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         OP_MULT:  return sa * sb;
         OP_MULTU: return ua * ub;
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (op == OP_DIV) return {32'(sa % sb), 32'(sa / sb)};
            return {32'(ua % ub), 32'(ua / ub)};
         end
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: idle/done cycles honour MT writes, an accepted start
   // schedules its result LATENCY edges later, and busy covers the gap.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mHi     <= '0;
         mLo     <= '0;
         mDone   <= 1'b0;
         mRemain <= 0;
      end else if (mDone) begin
         mDone <= 1'b0;
         if (tbBus.mthi) mHi <= tbBus.wdata;
         if (tbBus.mtlo) mLo <= tbBus.wdata;
      end else if (mRemain > 0) begin
         mRemain <= mRemain - 1;
         if (mRemain == 1) begin
            mHi   <= mPend[63:32];
            mLo   <= mPend[31:0];
            mDone <= 1'b1;
         end
      end else if (tbBus.start) begin
         mPend   <= expectedResult(tbBus.op, tbBus.a, tbBus.b);
         mRemain <= LATENCY;
      end else begin
         if (tbBus.mthi) mHi <= tbBus.wdata;
         if (tbBus.mtlo) mLo <= tbBus.wdata;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("model busy", {31'd0, tbBus.busy}, {31'd0, (mRemain > 0)});
         checkOutput("model done", {31'd0, tbBus.done}, {31'd0, mDone});
         checkOutput("model hi", tbBus.hi, mHi);
         checkOutput("model lo", tbBus.lo, mLo);
      end
   end

   // Present one operation for a single cycle while the unit is idle, then
   // scramble the operand lines to prove internal copies are used.
   task automatic applyStimulus(input op_t op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      tbBus.start = 1'b1;
      tbBus.op    = op;
      tbBus.a     = a;
      tbBus.b     = b;
      @(negedge clk);
      tbBus.start = 1'b0;
      tbBus.a     = $urandom();
      tbBus.b     = $urandom();
   endtask

   // Wait (bounded) for done; optionally disturb the running operation with
   // stray starts and an MTHI that must all be ignored.
   task automatic waitDone(input bit interfere, output int edges, output int busyCycles);
      edges      = 0;
      busyCycles = 0;
      while ((tbBus.done !== 1'b1) && (edges < 100)) begin
         if (tbBus.busy === 1'b1) busyCycles++;
         @(negedge clk);
         edges++;
         if (interfere) begin
            case (edges)
               5: begin
                  tbBus.start = 1'b1;
                  tbBus.op    = OP_MULTU;
                  tbBus.a     = 32'd3;
                  tbBus.b     = 32'd9;
               end
               20: begin
                  tbBus.start = 1'b1;
                  tbBus.op    = OP_DIV;
                  tbBus.a     = 32'd50;
                  tbBus.b     = 32'd5;
               end
               6, 21: tbBus.start = 1'b0;
               10: begin
                  tbBus.mthi  = 1'b1;
                  tbBus.wdata = 32'h55;
               end
               11: tbBus.mthi = 1'b0;
               default: begin
               end
            endcase
         end
      end
      if (edges >= 100) begin
         numChecks++;
         numFails++;
         $display("[TB] FAIL done timeout: got no done after %0d edges, expected done after %0d", edges, LATENCY);
      end
   endtask

   initial begin
      int edges;
      int busyCycles;
      tbBus.start = 1'b0;
      tbBus.op    = OP_MULT;
      tbBus.a     = '0;
      tbBus.b     = '0;
      tbBus.mthi  = 1'b0;
      tbBus.mtlo  = 1'b0;
      tbBus.wdata = '0;

      repeat (3) @(negedge clk);
      checkOutput("reset busy", {31'd0, tbBus.busy}, 32'd0);
      checkOutput("reset done", {31'd0, tbBus.done}, 32'd0);
      checkOutput("reset hi", tbBus.hi, 32'd0);
      checkOutput("reset lo", tbBus.lo, 32'd0);
      rst     = 1'b0;
      checkEn = 1'b1;

      $display("[TB] MULTU max*max latency");
      applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      waitDone(1'b0, edges, busyCycles);
      checkOutput("multu latency edges", edges, 32'd34);
      checkOutput("multu busy cycles", busyCycles, 32'd34);
      checkOutput("multu hi", tbBus.hi, 32'hFFFF_FFFE);
      checkOutput("multu lo", tbBus.lo, 32'h0000_0001);

      $display("[TB] signed MULT and DIV");
      applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7);
      waitDone(1'b0, edges, busyCycles);
      checkOutput("mult -3*7 hi", tbBus.hi, 32'hFFFF_FFFF);
      checkOutput("mult -3*7 lo", tbBus.lo, 32'hFFFF_FFEB);
      applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      waitDone(1'b0, edges, busyCycles);
      checkOutput("div -7/2 lo", tbBus.lo, 32'hFFFF_FFFD);
      checkOutput("div -7/2 hi", tbBus.hi, 32'hFFFF_FFFF);

      $display("[TB] divide by zero and signed overflow");
      applyStimulus(OP_DIVU, 32'd100, 32'd0);
      waitDone(1'b0, edges, busyCycles);
      checkOutput("divu by zero edges", edges, 32'd34);
      checkOutput("divu by zero lo", tbBus.lo, 32'hFFFF_FFFF);
      checkOutput("divu by zero hi", tbBus.hi, 32'd100);
      applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      waitDone(1'b0, edges, busyCycles);
      checkOutput("div overflow lo", tbBus.lo, 32'h8000_0000);
      checkOutput("div overflow hi", tbBus.hi, 32'd0);

      $display("[TB] ignored start and MTHI while busy");
      applyStimulus(OP_DIVU, 32'd1000, 32'd7);
      waitDone(1'b1, edges, busyCycles);
      checkOutput("divu 1000/7 edges", edges, 32'd34);
      checkOutput("divu 1000/7 lo", tbBus.lo, 32'd142);
      checkOutput("divu 1000/7 hi", tbBus.hi, 32'd6);

      $display("[TB] MTHI/MTLO in IDLE and DONE");
      @(negedge clk);
      tbBus.mtlo  = 1'b1;
      tbBus.wdata = 32'h1234;
      @(negedge clk);
      tbBus.mtlo  = 1'b0;
      checkOutput("idle mtlo lo", tbBus.lo, 32'h1234);
      checkOutput("idle mtlo hi kept", tbBus.hi, 32'd6);
      applyStimulus(OP_MULTU, 32'h0001_0000, 32'h10);
      waitDone(1'b0, edges, busyCycles);
      tbBus.mthi  = 1'b1;
      tbBus.wdata = 32'hAA;
      @(negedge clk);
      tbBus.mthi  = 1'b0;
      checkOutput("done mthi hi", tbBus.hi, 32'hAA);
      checkOutput("done mthi lo result", tbBus.lo, 32'h0010_0000);
      @(negedge clk);
      tbBus.start = 1'b1;
      tbBus.op    = OP_MULTU;
      tbBus.a     = 32'd2;
      tbBus.b     = 32'd3;
      tbBus.mtlo  = 1'b1;
      tbBus.wdata = 32'hDEAD;
      @(negedge clk);
      tbBus.start = 1'b0;
      tbBus.mtlo  = 1'b0;
      checkOutput("start+mtlo busy", {31'd0, tbBus.busy}, 32'd1);
      checkOutput("start+mtlo lo dropped", tbBus.lo, 32'h0010_0000);
      waitDone(1'b0, edges, busyCycles);
      checkOutput("start+mtlo result lo", tbBus.lo, 32'd6);
      checkOutput("start+mtlo result hi", tbBus.hi, 32'd0);

      $display("[TB] reset during MULT");
      applyStimulus(OP_MULT, 32'd5, 32'hFFFF_FFFB);
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("midop reset busy", {31'd0, tbBus.busy}, 32'd0);
      checkOutput("midop reset done", {31'd0, tbBus.done}, 32'd0);
      checkOutput("midop reset hi", tbBus.hi, 32'd0);
      checkOutput("midop reset lo", tbBus.lo, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(OP_MULTU, 32'd6, 32'd7);
      waitDone(1'b0, edges, busyCycles);
      checkOutput("post reset edges", edges, 32'd34);
      checkOutput("post reset lo", tbBus.lo, 32'd42);
      checkOutput("post reset hi", tbBus.hi, 32'd0);

      repeat (2) @(negedge clk);
      checkEn = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no end of test, expected finish before %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register read operands and computes MULT/MULTU/DIV/DIVU over several cycles.
- Holds results in architectural HI/LO registers, which the writeback path reads for MFHI/MFLO.
- Stalls the core through `busy` while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width; counter is clog2(WIDTH) bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  launch operation; sampled only when busy=0
- op  input  2  0=MULT (signed), 1=MULTU, 2=DIV (signed), 3=DIVU
- a  input  WIDTH  operand rs (multiplicand / dividend), from register read port 1
- b  input  WIDTH  operand rt (multiplier / divisor), from register read port 2
- mthi  input  1  write wdata into HI (MTHI)
- mtlo  input  1  write wdata into LO (MTLO)
- wdata  input  WIDTH  data for MTHI/MTLO
- busy  output  1  operation in progress; core must stall MFHI/MFLO/new muldiv ops
- done  output  1  one-cycle pulse when HI/LO receive a result
- hi  output  WIDTH  HI register: product upper half / remainder
- lo  output  WIDTH  LO register: product lower half / quotient

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, done=0, hi=0, lo=0; counter and internal accumulators cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 on an edge latches op, a and b.
  - Signed ops latch |a|, |b| plus the result sign bits.
  - Go to CALC with counter=0; busy=1 from that edge.
- CALC:
  - One radix-2 step per cycle, for exactly WIDTH cycles; counter 0..WIDTH-1. At counter=WIDTH-1 go to FIX.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
    - Remainder register is WIDTH+1 bits.
    - Quotient bit is 1 when the trial subtraction is non-negative.
- FIX (1 cycle): apply sign correction.
  - MULT: negate the 64-bit product if sign(a)^sign(b).
  - DIV: quotient negated if sign(a)^sign(b); remainder takes sign of a.
- DONE (1 cycle):
  - hi/lo are written on the edge entering DONE; done=1, busy=0 during DONE.
  - Next state is IDLE.
- Latency:
  - Start sampled on edge E0; hi/lo update and done rises on edge E0+WIDTH+2 (E34 at default).
  - busy is high for WIDTH+2 cycles.
- Back-to-back:
  - start is ignored in DONE (busy=0 but state not IDLE).
  - Earliest next accept is the edge leaving DONE. The control unit holds start until accepted.
- start while busy=1: ignored; no effect on the running operation.
- mthi/mtlo:
  - Take effect on the clock edge only in IDLE or DONE, and only when no start is accepted that edge.
  - Ignored in CALC/FIX.
  - In DONE, a MT write overrides the result for that register on the same edge.
  - start accepted in IDLE on the same edge as mthi/mtlo: start wins, the MT write is dropped.
- Divide by zero (b=0):
  - lo=all ones, hi=a (original signed/unsigned value).
  - Full latency still applies, no early exit.
- Signed overflow (DIV, a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0.
- MULTU/DIVU: operands are treated as unsigned; no sign fix.
- Reset mid-operation: immediate return to IDLE, hi/lo cleared, no done pulse.
- Operands a/b may change after the accepting edge; internal copies are used.

Decomposition:
- Shared package muldiv_pkg holds:
  - op_t enum (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - state_t enum (IDLE, CALC, FIX, DONE);
  - constant DIV0_QUOT = all ones.
- The main control unit imports op_t to drive op.
- One natural sub-module: muldiv_abs, the combinational magnitude + sign extractor, reused for both operands.
- The datapath and FSM stay in muldiv_unit.

Test Plan:
1. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done on 34th edge after start; hi=0xFFFFFFFE, lo=0x00000001; busy high 34 cycles.
2. MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
3. DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. start pulses with new operands at cycles 5 and 20 of a running DIVU 1000/7 -> ignored; result lo=142, hi=6. mthi=1 wdata=0x55 during CALC -> hi unaffected.
5. In IDLE, mtlo wdata=0x1234 -> lo=0x1234 next edge. In DONE cycle, mthi wdata=0xAA -> hi=0xAA, lo=new result. start+mtlo same IDLE edge -> operation runs, MT dropped.
6. Assert rst at cycle 10 of a MULT -> busy=0, done=0, hi=lo=0 immediately. After release, MULTU 6*7 -> lo=42, hi=0 with full latency.
